// File: rtl/clm_inv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clm_inv_sequencer
// Function : Masked GF(2^8) inversion (x^254) of one CLM codeword by driving an
//            external CLM multiplier through a square-and-multiply schedule.
// Revision : 1.0 - initial release
// ============================================================================
module clm_inv_sequencer #(
    parameter int D = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8+D-1:0] in_data,
    input  logic [D-1:0]   rnd_i,
    input  logic           rnd_valid,
    output logic           rnd_ready,
    output logic [8+D-1:0] mul_a,
    output logic [8+D-1:0] mul_b,
    output logic [D-1:0]   mul_r,
    input  logic [8+D-1:0] mul_out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8+D-1:0] out_data,
    output logic           busy
);

    localparam int c_WIDTH = 8 + D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_WIDTH-1:0]   r_x;
    logic [c_WIDTH-1:0]   w_x_nxt;
    logic [c_WIDTH-1:0]   r_acc;
    logic [c_WIDTH-1:0]   w_acc_nxt;
    logic [2:0]           r_cnt;
    logic [2:0]           w_cnt_nxt;
    logic                 w_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_acc   <= '0;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Six (square, multiply) pairs give x^127; the closing square yields x^254.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_step      = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        mul_a       = '0;
        mul_b       = '0;
        mul_r       = '0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_x_nxt     = in_data;
                    w_acc_nxt   = in_data;
                    w_cnt_nxt   = 3'd6;
                    w_state_nxt = SQR;
                end
            end
            SQR: begin
                w_step = 1'b1;
                mul_a  = r_acc;
                mul_b  = r_acc;
                mul_r  = rnd_i;
                if (rnd_valid) begin
                    w_acc_nxt   = mul_out;
                    w_state_nxt = (r_cnt == 3'd0) ? DONE : MUL;
                end
            end
            MUL: begin
                w_step = 1'b1;
                mul_a  = r_acc;
                mul_b  = r_x;
                mul_r  = rnd_i;
                if (rnd_valid) begin
                    w_acc_nxt   = mul_out;
                    w_cnt_nxt   = r_cnt - 3'd1;
                    w_state_nxt = SQR;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = r_acc;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rnd_ready = rnd_valid & w_step;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clm_inv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clm_inv_sequencer
// Function : Directed, table-driven bench for clm_inv_sequencer with a toy
//            masked multiplier (data byte in [7:0], randomness in mask field).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clm_inv_sequencer;

    localparam int c_D = 8;
    localparam int c_W = 8 + c_D;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] in_data;
    logic [c_D-1:0] rnd_i;
    logic           rnd_valid;
    logic           rnd_ready;
    logic [c_W-1:0] mul_a;
    logic [c_W-1:0] mul_b;
    logic [c_D-1:0] mul_r;
    logic [c_W-1:0] mul_out;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] out_data;
    logic           busy;

    int total = 0;
    int bad   = 0;

    clm_inv_sequencer #(.D(c_D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rnd_i     (rnd_i),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_r     (mul_r),
        .mul_out   (mul_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_inv(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 1; i < 256; i++) begin
            if (gf_mul(x, 8'(i)) == 8'h01) y = 8'(i);
        end
        return y;
    endfunction

    assign mul_out = {mul_r, gf_mul(mul_a[7:0], mul_b[7:0])};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation from IDLE and runs until out_valid.
    task automatic run_op(input logic [7:0] din, input bit rand_mode,
                          output logic [c_W-1:0] res, output int pulses,
                          output int lat, output bit stall_ok, output logic [c_D-1:0] last_r);
        logic [c_W-1:0] pa;
        logic [c_W-1:0] pb;
        logic           pv;
        in_data  = {8'h00, din};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        pulses   = 0;
        lat      = 0;
        stall_ok = 1'b1;
        last_r   = '0;
        while (!out_valid && lat < 400) begin
            rnd_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            rnd_i     = rand_mode ? c_D'($urandom) : '0;
            #1;
            pa = mul_a;
            pb = mul_b;
            pv = rnd_valid;
            if (rnd_ready !== rnd_valid || mul_r !== rnd_i) stall_ok = 1'b0;
            if (rnd_ready) begin
                pulses++;
                last_r = rnd_i;
            end
            tick();
            lat++;
            if (!pv && (mul_a !== pa || mul_b !== pb || out_valid)) stall_ok = 1'b0;
        end
        rnd_valid = 1'b0;
        if (lat >= 400) check("timeout", 32'(out_valid), 32'd1);
        res = out_data;
    endtask

    task automatic finish_op(input bit do_check);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (do_check) begin
            check("post_out_valid", 32'(out_valid), 32'd0);
            check("post_out_data", 32'(out_data), 32'd0);
            check("post_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] bseq[3];
    logic [7:0] bexp[3];

    initial begin
        logic [c_W-1:0] res;
        logic [c_D-1:0] lr;
        int  pulses;
        int  lat;
        bit  sok;
        int  idx;
        int  nout;
        int  cyc;
        int  last_cyc;
        bit  acc;

        tbl[0] = '{8'h02, 8'h8D};
        tbl[1] = '{8'h01, 8'h01};
        tbl[2] = '{8'h53, 8'hCA};
        tbl[3] = '{8'h00, 8'h00};
        tbl[4] = '{8'h8D, 8'h02};
        tbl[5] = '{8'hCA, 8'h53};
        bseq[0] = 8'h02; bexp[0] = 8'h8D;
        bseq[1] = 8'h53; bexp[1] = 8'hCA;
        bseq[2] = 8'h01; bexp[2] = 8'h01;

        rst = 1'b1; in_valid = 1'b1; in_data = 16'h00AA; rnd_i = 8'h5A;
        rnd_valid = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rnd_ready", 32'(rnd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_mul", 32'({mul_a, mul_b}), 32'd0);
        check("rst_mul_r", 32'(mul_r), 32'd0);
        rnd_valid = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_op(tbl[v].din, 1'b0, res, pulses, lat, sok, lr);
            check($sformatf("vec%0d_data", v), 32'(res[7:0]), 32'(tbl[v].exp));
            check($sformatf("vec%0d_mask", v), 32'(res[c_W-1:8]), 32'd0);
            check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'd13);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd13);
            check($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'd0);
            finish_op(1'b1);
        end

        for (int x = 0; x < 256; x++) begin
            run_op(8'(x), 1'b1, res, pulses, lat, sok, lr);
            check($sformatf("rand%0d_data", x), 32'(res[7:0]), 32'(ref_inv(8'(x))));
            check($sformatf("rand%0d_mask", x), 32'(res[c_W-1:8]), 32'(lr));
            check($sformatf("rand%0d_pulses", x), 32'(pulses), 32'd13);
            check($sformatf("rand%0d_stall", x), 32'(sok), 32'd1);
            finish_op(1'b0);
        end

        // Output back-pressure: result holds, new operand is ignored.
        run_op(8'h53, 1'b0, res, pulses, lat, sok, lr);
        in_valid = 1'b1;
        in_data  = 16'h0002;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_out_data", 32'(out_data), 32'h00CA);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
        run_op(8'h02, 1'b0, res, pulses, lat, sok, lr);
        check("after_hold_data", 32'(res), 32'h008D);
        finish_op(1'b1);

        // Reset in the 5th multiplication step.
        in_data  = 16'h0002;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        rnd_valid = 1'b1;
        rnd_i     = '0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_rnd_ready", 32'(rnd_ready), 32'd0);
        check("midrst_mul", 32'({mul_a, mul_b}), 32'd0);
        check("midrst_mul_r", 32'(mul_r), 32'd0);
        rnd_valid = 1'b0;
        run_op(8'h02, 1'b0, res, pulses, lat, sok, lr);
        check("midrst_redo", 32'(res), 32'h008D);
        finish_op(1'b1);

        // Back-to-back streaming.
        idx = 0; nout = 0; cyc = 0; last_cyc = 0;
        in_valid = 1'b1; out_ready = 1'b1; rnd_valid = 1'b1; rnd_i = '0;
        in_data = {8'h00, bseq[0]};
        while (nout < 3 && cyc < 200) begin
            acc = in_ready && in_valid;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 3) in_data = {8'h00, bseq[idx]};
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                check($sformatf("b2b%0d_data", nout), 32'(out_data), 32'(bexp[nout]));
                if (nout > 0) check($sformatf("b2b%0d_gap", nout), 32'(cyc - last_cyc), 32'd15);
                last_cyc = cyc;
                nout++;
            end
        end
        check("b2b_count", 32'(nout), 32'd3);
        in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
